// File: rtl/uart_pkg.sv
// Shared types, constants and the baud divisor lookup for the UART transmitter.
package uart_pkg;

   localparam int MAX_DATA_BITS = 8;

   typedef enum logic [1:0] {
      FRAME_5 = 2'b00,
      FRAME_6 = 2'b01,
      FRAME_7 = 2'b10,
      FRAME_8 = 2'b11
   } frame_t;

   typedef enum logic [1:0] {
      PAR_NONE     = 2'b00,
      PAR_EVEN     = 2'b01,
      PAR_ODD      = 2'b10,
      PAR_NONE_ALT = 2'b11
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam logic [3:0] BAUD_1200   = 4'd0;
   localparam logic [3:0] BAUD_2400   = 4'd1;
   localparam logic [3:0] BAUD_4800   = 4'd2;
   localparam logic [3:0] BAUD_9600   = 4'd3;
   localparam logic [3:0] BAUD_19200  = 4'd4;
   localparam logic [3:0] BAUD_38400  = 4'd5;
   localparam logic [3:0] BAUD_57600  = 4'd6;
   localparam logic [3:0] BAUD_115200 = 4'd7;
   localparam logic [3:0] BAUD_230400 = 4'd8;

   // Bit period in clock cycles; every branch divides by a constant so it folds to a table.
   function automatic logic [15:0] baud_div(input logic [3:0] idx, input int unsigned clk_hz);
      int unsigned div;
      case (idx)
         BAUD_1200:   div = clk_hz / 1200;
         BAUD_2400:   div = clk_hz / 2400;
         BAUD_4800:   div = clk_hz / 4800;
         BAUD_9600:   div = clk_hz / 9600;
         BAUD_19200:  div = clk_hz / 19200;
         BAUD_38400:  div = clk_hz / 38400;
         BAUD_57600:  div = clk_hz / 57600;
         BAUD_230400: div = clk_hz / 230400;
         default:     div = clk_hz / 115200;
      endcase
      return div[15:0];
   endfunction

endpackage

// File: rtl/uart_if.sv
// Control-register fields consumed by the transmitter plus the request-clear return path.
interface uart_if;
   import uart_pkg::*;

   // Handshake: tnsm is a level request held by the register. The transmitter
   // accepts it in IDLE and raises tnsm_clr the next cycle; tnsm_clr stays high
   // until tnsm is seen low, and no further frame is accepted while it is high,
   // so a clear lost to a concurrent register write is retried, never resent.
   logic        active;
   frame_t      frame_type;
   parity_t     parity_type;
   logic        stop_type;
   logic [3:0]  baud_rate;
   logic        tnsm;
   logic [7:0]  tnsm_data;
   logic        tnsm_clr;

   modport master (
      output active, frame_type, parity_type, stop_type, baud_rate, tnsm, tnsm_data,
      input  tnsm_clr
   );

   modport slave (
      input  active, frame_type, parity_type, stop_type, baud_rate, tnsm, tnsm_data,
      output tnsm_clr
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Loadable down-counter producing a one-cycle tick at the end of each bit period.
module uart_baud_gen (
   input  logic        clk,
   input  logic        arst_n,
   input  logic [15:0] period,
   input  logic        restart,
   output logic        bit_tick
);

   logic [15:0] cnt_q, cnt_d;

   // Reload on restart or at period end, otherwise count down.
   always_comb begin
      bit_tick = 1'b0;
      cnt_d    = cnt_q - 16'd1;
      if (restart) begin
         cnt_d = period - 16'd1;
      end else if (cnt_q == 16'd0) begin
         bit_tick = 1'b1;
         cnt_d    = period - 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!arst_n) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: accepts a frame from the control register and serialises it.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
   input  logic      clk,
   input  logic      arst_n,
   uart_if.slave     regs,
   output logic      tx,
   output logic      busy,
   output logic      tx_done,
   output tx_state_t state_dbg
);

   tx_state_t   state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        stop_idx_q, stop_idx_d;
   frame_t      frame_q, frame_d;
   logic        stop_two_q, stop_two_d;
   logic        par_en_q, par_en_d;
   logic        par_bit_q, par_bit_d;
   logic [15:0] period_q, period_d;
   logic        clr_pending_q, clr_pending_d;
   logic        tx_q, tx_d;
   logic        tx_done_q, tx_done_d;

   logic        accept;
   logic        bit_tick;
   logic [15:0] new_period;
   logic [1:0]  ft;
   logic [7:0]  data_mask;
   logic [2:0]  last_bit;

   assign accept     = (state_q == ST_IDLE) && regs.active && regs.tnsm && !clr_pending_q;
   assign new_period = baud_div(regs.baud_rate, CLK_FREQ_HZ);
   assign ft         = regs.frame_type;
   assign data_mask  = 8'hFF >> (2'd3 - ft);
   assign last_bit   = 3'd4 + {1'b0, frame_q};

   uart_baud_gen u_baud (
      .clk      (clk),
      .arst_n   (arst_n),
      .period   (accept ? new_period : period_q),
      .restart  (accept),
      .bit_tick (bit_tick)
   );

   // Next-state, shadow capture, request-clear tracking and registered tx level.
   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_idx_d     = bit_idx_q;
      stop_idx_d    = stop_idx_q;
      frame_d       = frame_q;
      stop_two_d    = stop_two_q;
      par_en_d      = par_en_q;
      par_bit_d     = par_bit_q;
      period_d      = period_q;
      clr_pending_d = clr_pending_q && regs.tnsm;
      tx_done_d     = 1'b0;
      tx_d          = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shift_d       = regs.tnsm_data;
               frame_d       = regs.frame_type;
               stop_two_d    = regs.stop_type;
               par_en_d      = (regs.parity_type == PAR_EVEN) || (regs.parity_type == PAR_ODD);
               par_bit_d     = (regs.parity_type == PAR_ODD) ^ (^(regs.tnsm_data & data_mask));
               period_d      = new_period;
               clr_pending_d = 1'b1;
               bit_idx_d     = '0;
               stop_idx_d    = 1'b0;
               state_d       = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == last_bit) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (bit_tick) begin
               if (stop_two_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  state_d   = ST_IDLE;
                  tx_done_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_bit_d;
         default:   tx_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q       <= ST_IDLE;
         shift_q       <= '0;
         bit_idx_q     <= '0;
         stop_idx_q    <= 1'b0;
         frame_q       <= FRAME_5;
         stop_two_q    <= 1'b0;
         par_en_q      <= 1'b0;
         par_bit_q     <= 1'b0;
         period_q      <= '0;
         clr_pending_q <= 1'b0;
         tx_q          <= 1'b1;
         tx_done_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_idx_q     <= bit_idx_d;
         stop_idx_q    <= stop_idx_d;
         frame_q       <= frame_d;
         stop_two_q    <= stop_two_d;
         par_en_q      <= par_en_d;
         par_bit_q     <= par_bit_d;
         period_q      <= period_d;
         clr_pending_q <= clr_pending_d;
         tx_q          <= tx_d;
         tx_done_q     <= tx_done_d;
      end
   end

   assign tx            = tx_q;
   assign busy          = (state_q != ST_IDLE);
   assign tx_done       = tx_done_q;
   assign state_dbg     = state_q;
   assign regs.tnsm_clr = clr_pending_q;

endmodule
